fifo_rd_stream: RTL and testbench



---
 rtl/fifo_pkg.sv | 24 ++
 rtl/skid_buf2.sv | 60 ++++++
 rtl/fifo_rd_stream.sv | 84 ++++++++
 tb/tb_fifo_rd_stream.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
package fifo_pkg;

    // Depth of the output skid buffer; two entries cover the 1-cycle pop latency.
    localparam int SKID_DEPTH = 2;

    // Width of the skid buffer occupancy count (0..SKID_DEPTH).
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    // Default word width and packet length.
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PKT_LEN    = 16;

    // $clog2 that never returns less than 1, so a counter always has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry synchronous buffer with simultaneous write and read support.
// The head entry is a register, so the output never depends combinationally
// on the write data. Writes into a full buffer without a read, and reads from
// an empty buffer, are ignored.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd,
    output logic [SKID_CNT_W-1:0] cnt,
    output logic [DATA_WIDTH-1:0] head
);

    localparam logic [SKID_CNT_W-1:0] CNT_FULL = SKID_CNT_W'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;

    // Qualify requests against occupancy; a read frees a slot in the same cycle.
    always_comb begin
        rd_ok = rd & (cnt != '0);
        wr_ok = wr & ((cnt != CNT_FULL) | rd_ok);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + SKID_CNT_W'(1);
                2'b01:   cnt <= cnt - SKID_CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pops a FIFO with 1-cycle read latency and presents the
// words on a valid/ready stream at one word per cycle, marking packet ends.
//
// Stream handshake: a word transfers on every rising edge where m_valid and
// m_ready are both high (fire). m_valid never depends on m_ready, and once
// m_valid is high, m_data and m_last hold until the word is accepted.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PKT_LEN    = DEF_PKT_LEN,
    parameter int CNT_WIDTH  = clog2_min1(PKT_LEN)
) (
    input  logic                  rclk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0]  LAST_IDX  = CNT_WIDTH'(PKT_LEN - 1);
    localparam logic [SKID_CNT_W:0]   USED_FULL = (SKID_CNT_W + 1)'(SKID_DEPTH);

    logic [SKID_CNT_W-1:0] buf_cnt;
    logic [SKID_CNT_W:0]   used;
    logic                  inflight;
    logic                  fire;
    logic                  room;
    logic [CNT_WIDTH-1:0]  word_cnt;

    // Pop rule: words already buffered plus the one in flight must leave a
    // slot, either free now or freed by this cycle's transfer. Held off in reset.
    always_comb begin
        fire       = m_valid & m_ready;
        used       = {1'b0, buf_cnt} + {{SKID_CNT_W{1'b0}}, inflight};
        room       = (used < USED_FULL) | ((used == USED_FULL) & fire);
        fifo_rd_en = ~rst & en & ~fifo_empty & room;
    end

    // A pop accepted this cycle returns its word on fifo_rdata next cycle.
    always_ff @(posedge rclk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    // Word position inside the current packet; advances on each transfer.
    always_ff @(posedge rclk) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (fire) begin
            if (word_cnt == LAST_IDX) begin
                word_cnt <= '0;
            end else begin
                word_cnt <= word_cnt + CNT_WIDTH'(1);
            end
        end
    end

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk   (rclk),
        .rst   (rst),
        .wr    (inflight),
        .wdata (fifo_rdata),
        .rd    (fire),
        .cnt   (buf_cnt),
        .head  (m_data)
    );

    assign m_valid = (buf_cnt != '0);
    assign m_last  = m_valid & (word_cnt == LAST_IDX);
    assign busy    = m_valid | inflight;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-backed FIFO model feeds two instances
// (PKT_LEN=16 and PKT_LEN=1); a scoreboard checks every accepted beat.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int PL = 16;

  // clock / reset
  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic rst = 1'b1;
  logic en = 1'b0;
  logic m_ready = 1'b0;

  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rd_en, m_valid, m_last, busy;
  logic [DW-1:0] m_data;

  logic          fifo_empty1 = 1'b1;
  logic [DW-1:0] fifo_rdata1 = '0;
  logic          fifo_rd_en1, m_valid1, m_last1, busy1;
  logic [DW-1:0] m_data1;

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .rclk(rclk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy)
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut1 (
    .rclk(rclk), .rst(rst), .en(en), .fifo_empty(fifo_empty1), .fifo_rdata(fifo_rdata1),
    .fifo_rd_en(fifo_rd_en1), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .m_last(m_last1), .busy(busy1)
  );

  // FIFO contents and scoreboard queues
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] src_q1[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_q1[$];

  int total = 0;
  int bad = 0;
  int beat_idx = 0;
  int out_cnt = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  // per-cycle samples taken at the falling edge
  logic s_pop, s_valid, s_busy, s_fire, s_fire1, s_busy1;

  task automatic push0(input logic [DW-1:0] d);
    src_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic push1(input logic [DW-1:0] d);
    src_q1.push_back(d);
    exp_q1.push_back(d);
  endtask

  // One clock: sample and score at negedge, advance the FIFO models at posedge.
  task automatic step();
    logic pop0, pop1, exp_rd, exp_l;
    logic [DW-1:0] exp_d;
    @(negedge rclk);
    s_pop   = fifo_rd_en;
    s_valid = m_valid;
    s_busy  = busy;
    s_busy1 = busy1;
    s_fire  = m_valid & m_ready;
    s_fire1 = m_valid1 & m_ready;

    exp_rd = !rst && en && !fifo_empty && (out_cnt < 2 || (out_cnt == 2 && s_fire));
    total++;
    if (fifo_rd_en !== exp_rd) begin
      bad++;
      $display("FAIL pop_rule t=%0t: fifo_rd_en=%b expected=%b (used=%0d empty=%b)",
               $time, fifo_rd_en, exp_rd, out_cnt, fifo_empty);
    end

    if (fifo_empty1) begin
      total++;
      if (fifo_rd_en1 !== 1'b0) begin
        bad++;
        $display("FAIL pop_while_empty1 t=%0t: fifo_rd_en1=%b expected=0", $time, fifo_rd_en1);
      end
    end

    if (prev_stall && !rst) begin
      total++;
      if (m_data !== prev_data || m_last !== prev_last) begin
        bad++;
        $display("FAIL stall_hold t=%0t: data=%0h last=%b expected data=%0h last=%b",
                 $time, m_data, m_last, prev_data, prev_last);
      end
    end
    prev_stall = m_valid & !m_ready & !rst;
    prev_data  = m_data;
    prev_last  = m_last;

    if (s_fire && !rst) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_beat t=%0t: data=%0h expected no beat", $time, m_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (m_data !== exp_d) begin
          bad++;
          $display("FAIL beat_data t=%0t: data=%0h expected=%0h", $time, m_data, exp_d);
        end
        exp_l = (beat_idx == PL - 1);
        total++;
        if (m_last !== exp_l) begin
          bad++;
          $display("FAIL beat_last t=%0t: last=%b expected=%b (word %0d)", $time, m_last, exp_l, beat_idx);
        end
        beat_idx = (beat_idx + 1) % PL;
      end
    end

    if (s_fire1 && !rst) begin
      total++;
      if (exp_q1.size() == 0) begin
        bad++;
        $display("FAIL extra_beat1 t=%0t: data=%0h expected no beat", $time, m_data1);
      end else begin
        exp_d = exp_q1.pop_front();
        if (m_data1 !== exp_d || m_last1 !== 1'b1) begin
          bad++;
          $display("FAIL beat1 t=%0t: data=%0h last=%b expected data=%0h last=1",
                   $time, m_data1, m_last1, exp_d);
        end
      end
    end

    if (rst) begin
      out_cnt  = 0;
      beat_idx = 0;
    end else begin
      out_cnt = out_cnt + (fifo_rd_en ? 1 : 0) - (s_fire ? 1 : 0);
    end
    pop0 = fifo_rd_en;
    pop1 = fifo_rd_en1;

    @(posedge rclk);
    if (pop0 && src_q.size() != 0) fifo_rdata <= src_q.pop_front();
    if (pop1 && src_q1.size() != 0) fifo_rdata1 <= src_q1.pop_front();
    fifo_empty  <= (src_q.size() == 0);
    fifo_empty1 <= (src_q1.size() == 0);
    #1;
  endtask

  // Step until both scoreboards are drained and both instances idle.
  task automatic drain(input string name, input int max_cycles, output int beats, output int pops);
    int c;
    c = 0;
    beats = 0;
    pops = 0;
    while ((exp_q.size() != 0 || exp_q1.size() != 0 || busy || busy1) && c < max_cycles) begin
      step();
      if (s_fire) beats++;
      if (s_fire1) beats++;
      if (s_pop) pops++;
      c++;
    end
    total++;
    if (c >= max_cycles) begin
      bad++;
      $display("FAIL %s_timeout: cycles=%0d expected drain within %0d (left=%0d)",
               name, c, max_cycles, exp_q.size() + exp_q1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    total += 6;
    if (m_valid !== 1'b0)    begin bad++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    if (m_last !== 1'b0)     begin bad++; $display("FAIL reset_last: got %b expected 0", m_last); end
    if (m_data !== '0)       begin bad++; $display("FAIL reset_data: got %0h expected 0", m_data); end
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (m_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_dut1: valid=%b busy=%b expected 0 0", m_valid1, busy1);
    end
    step();
  endtask

  task automatic test_burst();
    int c, first_pop, first_valid, first_beat, last_beat, pops, beats;
    c = 0; first_pop = -1; first_valid = -1; first_beat = -1; last_beat = -1; pops = 0; beats = 0;
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push0(DW'(i));
    while ((exp_q.size() != 0 || busy) && c < 100) begin
      step();
      if (s_pop) begin pops++; if (first_pop < 0) first_pop = c; end
      if (s_valid && first_valid < 0) first_valid = c;
      if (s_fire) begin beats++; if (first_beat < 0) first_beat = c; last_beat = c; end
      c++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (s_pop) pops++;
    end
    total += 5;
    if (c >= 100) begin bad++; $display("FAIL burst_timeout: cycles=%0d expected <100", c); end
    if (first_valid - first_pop != 2) begin
      bad++; $display("FAIL burst_latency: got %0d expected 2", first_valid - first_pop);
    end
    if (pops != 16) begin bad++; $display("FAIL burst_pops: got %0d expected 16", pops); end
    if (beats != 16) begin bad++; $display("FAIL burst_beats: got %0d expected 16", beats); end
    if (last_beat - first_beat != 15) begin
      bad++; $display("FAIL burst_bubbles: span=%0d expected 15", last_beat - first_beat);
    end
  endtask

  task automatic test_backpressure();
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    int c, beats, pops;
    c = 0; beats = 0; pops = 0;
    en = 1'b1;
    for (int i = 0; i < 16; i++) push0(DW'(8'hA0 + i));
    while ((exp_q.size() != 0 || busy) && c < 300) begin
      m_ready = pat[c % 6][0];
      step();
      if (s_fire) beats++;
      if (s_pop) pops++;
      c++;
    end
    m_ready = 1'b1;
    total += 3;
    if (c >= 300) begin bad++; $display("FAIL bp_timeout: cycles=%0d expected <300", c); end
    if (beats != 16) begin bad++; $display("FAIL bp_beats: got %0d expected 16", beats); end
    if (pops != 16) begin bad++; $display("FAIL bp_pops: got %0d expected 16", pops); end
  endtask

  task automatic test_empty_gap();
    int beats, pops;
    en = 1'b1;
    m_ready = 1'b1;
    push0(8'h11); push0(8'h22); push0(8'h33);
    drain("gap_first", 50, beats, pops);
    total++;
    if (beats != 3) begin bad++; $display("FAIL gap_first_beats: got %0d expected 3", beats); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_pop !== 1'b0) begin
        bad++;
        $display("FAIL gap_idle: busy=%b valid=%b pop=%b expected 0 0 0", s_busy, s_valid, s_pop);
      end
    end
    push0(8'h44);
    drain("gap_refill", 50, beats, pops);
    total++;
    if (beats != 1) begin bad++; $display("FAIL gap_refill_beats: got %0d expected 1", beats); end
  endtask

  task automatic test_en_drop();
    int pops, beats;
    pops = 0; beats = 0;
    en = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push0(DW'(8'hB0 + i));
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_pop) pops++;
    end
    total += 2;
    if (pops != 2) begin bad++; $display("FAIL en_fill_pops: got %0d expected 2", pops); end
    if (s_valid !== 1'b1) begin bad++; $display("FAIL en_fill_valid: got %b expected 1", s_valid); end
    m_ready = 1'b1;
    step();
    if (s_fire) beats++;
    total++;
    if (s_pop !== 1'b1) begin bad++; $display("FAIL en_last_pop: got %b expected 1", s_pop); end
    en = 1'b0;
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_fire) beats++;
      if (s_pop) pops++;
    end
    total += 5;
    if (beats != 3) begin bad++; $display("FAIL en_drop_beats: got %0d expected 3", beats); end
    if (pops != 0) begin bad++; $display("FAIL en_drop_pops: got %0d expected 0", pops); end
    if (s_valid !== 1'b0) begin bad++; $display("FAIL en_drop_valid: got %b expected 0", s_valid); end
    if (s_busy !== 1'b0) begin bad++; $display("FAIL en_drop_busy: got %b expected 0", s_busy); end
    if (src_q.size() != 3) begin bad++; $display("FAIL en_drop_left: got %0d expected 3", src_q.size()); end
    en = 1'b1;
    drain("en_resume", 50, beats, pops);
    total++;
    if (beats != 3) begin bad++; $display("FAIL en_resume_beats: got %0d expected 3", beats); end
  endtask

  task automatic test_reset_mid();
    int beats, pops;
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push0(DW'(8'h60 + i));
    for (int i = 0; i < 4; i++) step();
    total++;
    if (s_valid !== 1'b1 || s_pop !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre: valid=%b pop=%b expected 1 1", s_valid, s_pop);
    end
    rst = 1'b1;
    src_q.delete();
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    total++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_pop !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_post: valid=%b busy=%b pop=%b expected 0 0 0", s_valid, s_busy, s_pop);
    end
    for (int i = 0; i < 16; i++) push0(DW'(8'h55 + i));
    drain("rstmid_refill", 80, beats, pops);
    total++;
    if (beats != 16) begin bad++; $display("FAIL rstmid_beats: got %0d expected 16", beats); end
  endtask

  task automatic test_pkt_len1();
    int c, beats;
    c = 0; beats = 0;
    en = 1'b1;
    for (int i = 1; i <= 4; i++) push1(DW'(i));
    while ((exp_q1.size() != 0 || busy1) && c < 100) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
      if (s_fire1) beats++;
      c++;
    end
    m_ready = 1'b1;
    total += 2;
    if (c >= 100) begin bad++; $display("FAIL len1_timeout: cycles=%0d expected <100", c); end
    if (beats != 4) begin bad++; $display("FAIL len1_beats: got %0d expected 4", beats); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_empty_gap();
    test_en_drop();
    test_reset_mid();
    test_pkt_len1();
    total++;
    if (exp_q.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d words expected 0", exp_q.size() + exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
